// File: rtl/sr_ff_bank.sv
// WIDTH-channel clocked SR/JK/D/T flip-flop bank with sticky invalid-SR detection.
// Optional macro SR_FF_BANK_ERR_CNT_EN adds the saturating invalid-cycle counter on ERR_CNT.

module sr_ff_cell (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       inv
);
  localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    inv   = 1'b0;
    if (en) begin
      case (mode)
        M_SR: begin
          if (s && r) inv   = 1'b1;
          else if (s) q_nxt = 1'b1;
          else if (r) q_nxt = 1'b0;
        end
        M_JK: begin
          if (s && r) q_nxt = ~q;
          else if (s) q_nxt = 1'b1;
          else if (r) q_nxt = 1'b0;
        end
        M_D:     q_nxt = s;
        default: if (s) q_nxt = ~q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) q <= 1'b0;
    else        q <= q_nxt;
  end
endmodule

module sr_ff_bank #(
  parameter int WIDTH      = 8,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             MODE_LD,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic [WIDTH-1:0] ERR_VEC,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);
  logic [WIDTH-1:0] s_a, r_a, inv_vec;
  logic [1:0]       mode_r;
  logic             any_inv;

  assign s_a     = (ACTIVE_LOW != 0) ? ~S : S;
  assign r_a     = (ACTIVE_LOW != 0) ? ~R : R;
  assign any_inv = |inv_vec;
  assign QBAR    = ~Q;

  // Mode load ignores EN so the bank can be reconfigured while frozen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       mode_r <= 2'b00;
    else if (MODE_LD) mode_r <= MODE;
  end

  sr_ff_cell u_cell [WIDTH-1:0] (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (EN),
    .mode  (mode_r),
    .s     (s_a),
    .r     (r_a),
    .q     (Q),
    .inv   (inv_vec)
  );

  // A clear coinciding with a fresh invalid event keeps the new event.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR_VEC <= '0;
      ERR     <= 1'b0;
    end else if (CLR_ERR) begin
      ERR_VEC <= inv_vec;
      ERR     <= any_inv;
    end else begin
      ERR_VEC <= ERR_VEC | inv_vec;
      ERR     <= ERR | any_inv;
    end
  end

`ifdef SR_FF_BANK_ERR_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ERR_CNT <= '0;
    else if (CLR_ERR)
      ERR_CNT <= any_inv ? CNT_W'(1) : '0;
    else if (any_inv && (ERR_CNT != {CNT_W{1'b1}}))
      ERR_CNT <= ERR_CNT + CNT_W'(1);
  end
`else
  assign ERR_CNT = '0;
`endif
endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: directed vector table, reset corner cases, randomized run vs. model.
module tb_sr_ff_bank;
  localparam int WIDTH = 4, ACTIVE_LOW = 1, CNT_W = 2;
`ifdef SR_FF_BANK_ERR_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0, RST_N = 1'b0, EN = 1'b0, MODE_LD = 1'b0, CLR_ERR = 1'b0;
  logic [1:0]       MODE = 2'b00;
  logic [WIDTH-1:0] S = '1, R = '1;
  logic [WIDTH-1:0] Q, QBAR, ERR_VEC;
  logic             ERR;
  logic [CNT_W-1:0] ERR_CNT;

  sr_ff_bank #(.WIDTH(WIDTH), .ACTIVE_LOW(ACTIVE_LOW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .MODE_LD(MODE_LD),
    .S(S), .R(R), .CLR_ERR(CLR_ERR), .Q(Q), .QBAR(QBAR),
    .ERR_VEC(ERR_VEC), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  // Behavioural reference: one int per channel, mode as a number.
  int mq[WIDTH];
  int merr[WIDTH];
  int mmode, mcnt;

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) begin mq[i] = 0; merr[i] = 0; end
    mmode = 0; mcnt = 0;
  endtask

  task automatic model_step();
    int any_bad;
    any_bad = 0;
    if (CLR_ERR) begin
      for (int i = 0; i < WIDTH; i++) merr[i] = 0;
      mcnt = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      int sa, ra;
      sa = ACTIVE_LOW ? (S[i] ? 0 : 1) : (S[i] ? 1 : 0);
      ra = ACTIVE_LOW ? (R[i] ? 0 : 1) : (R[i] ? 1 : 0);
      if (EN) begin
        if (mmode == 0) begin
          if (sa + ra == 2) begin any_bad = 1; merr[i] = 1; end
          else if (sa == 1) mq[i] = 1;
          else if (ra == 1) mq[i] = 0;
        end else if (mmode == 1) begin
          if (sa + ra == 2) mq[i] = 1 - mq[i];
          else if (sa == 1) mq[i] = 1;
          else if (ra == 1) mq[i] = 0;
        end else if (mmode == 2) mq[i] = sa;
        else if (sa == 1) mq[i] = 1 - mq[i];
      end
    end
    if (any_bad && CNT_ON && mcnt < CNT_MAX) mcnt = mcnt + 1;
    if (MODE_LD) mmode = MODE;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int pack(input int a[WIDTH]);
    int v;
    v = 0;
    for (int i = 0; i < WIDTH; i++) if (a[i] != 0) v |= (1 << i);
    return v;
  endfunction

  task automatic chk_all(input string tag, input int q, input int ev, input int e, input int c);
    chk({tag, ".Q"}, int'(Q), q);
    chk({tag, ".QBAR"}, int'(QBAR), (~q) & ((1 << WIDTH) - 1));
    chk({tag, ".ERR_VEC"}, int'(ERR_VEC), ev);
    chk({tag, ".ERR"}, int'(ERR), e);
    chk({tag, ".ERR_CNT"}, int'(ERR_CNT), CNT_ON ? c : 0);
  endtask

  task automatic chk_model(input string tag);
    int ev;
    ev = pack(merr);
    chk_all(tag, pack(mq), ev, (ev != 0) ? 1 : 0, mcnt);
  endtask

  // Drive inputs, advance one edge, update model, sample 1 time unit later.
  task automatic cycle(input logic en, input logic [1:0] md, input logic ld,
                       input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r, input logic clr);
    EN = en; MODE = md; MODE_LD = ld; S = s; R = r; CLR_ERR = clr;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  typedef struct {
    logic en; logic [1:0] md; logic ld; logic [3:0] s; logic [3:0] r; logic clr;
    int q; int ev; int e; int c;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic en, input logic [1:0] md, input logic ld,
                             input logic [3:0] s, input logic [3:0] r, input logic clr,
                             input int q, input int ev, input int e, input int c);
    vec_t t;
    t.en = en; t.md = md; t.ld = ld; t.s = s; t.r = r; t.clr = clr;
    t.q = q; t.ev = ev; t.e = e; t.c = c;
    return t;
  endfunction

  initial begin
    // SR basics
    tbl.push_back(v(1, 2'b00, 0, 4'b1110, 4'b1111, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b1111, 4'b1110, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b1110, 4'b1111, 0, 4'b0001, 0, 0, 0));
    // invalid on bit3, counter saturation, clear, clear+event
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 0, 4'b0001, 4'b1000, 1, 1));
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 0, 4'b0001, 4'b1000, 1, 2));
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 0, 4'b0001, 4'b1000, 1, 3));
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 0, 4'b0001, 4'b1000, 1, 3));
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 0, 4'b0001, 4'b1000, 1, 3));
    tbl.push_back(v(1, 2'b00, 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b0111, 4'b0111, 1, 4'b0001, 4'b1000, 1, 1));
    tbl.push_back(v(1, 2'b00, 0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 0));
    // JK loaded on an SR edge, then toggling
    tbl.push_back(v(1, 2'b01, 1, 4'b1011, 4'b1111, 0, 4'b0101, 0, 0, 0));
    tbl.push_back(v(1, 2'b01, 0, 4'b0000, 4'b0000, 0, 4'b1010, 0, 0, 0));
    tbl.push_back(v(1, 2'b01, 0, 4'b0000, 4'b0000, 0, 4'b0101, 0, 0, 0));
    tbl.push_back(v(1, 2'b01, 0, 4'b0000, 4'b0000, 0, 4'b1010, 0, 0, 0));
    // D
    tbl.push_back(v(1, 2'b10, 1, 4'b1111, 4'b1111, 0, 4'b1010, 0, 0, 0));
    tbl.push_back(v(1, 2'b10, 0, 4'b0011, 4'b1111, 0, 4'b1100, 0, 0, 0));
    tbl.push_back(v(1, 2'b10, 0, 4'b1010, 4'b0000, 0, 4'b0101, 0, 0, 0));
    // T
    tbl.push_back(v(1, 2'b11, 1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 4'b1100, 4'b0000, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 4'b1100, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 2'b11, 0, 4'b1100, 4'b0000, 0, 4'b0011, 0, 0, 0));
    // back to SR, then EN=0 holds and suppresses detection
    tbl.push_back(v(1, 2'b00, 1, 4'b1111, 4'b1111, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4'b0000, 4'b1111, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 4'b0000, 4'b0000, 0, 4'b0011, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b0000, 4'b1111, 0, 4'b1111, 0, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 4'b0000, 4'b0000, 0, 4'b1111, 4'b1111, 1, 1));
    tbl.push_back(v(0, 2'b00, 0, 4'b0000, 4'b0000, 1, 4'b1111, 0, 0, 0));

    model_reset();
    repeat (2) @(posedge CLK);
    #1 chk_all("reset", 0, 0, 0, 0);
    @(negedge CLK) RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].md, tbl[i].ld, tbl[i].s, tbl[i].r, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].ev, tbl[i].e, tbl[i].c);
    end

    // Mid-cycle async reset with live state and errors
    cycle(1, 2'b00, 0, 4'b1111, 4'b0101, 0);
    cycle(1, 2'b00, 0, 4'b0111, 4'b0111, 0);
    chk_all("pre_rst", 4'b0101, 4'b1000, 1, 1);
    #2 RST_N = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0);
    model_reset();
    // A mode load while in reset must be discarded
    cycle(1, 2'b01, 1, 4'b0000, 4'b0000, 0);
    model_reset();
    chk_all("rst_hold", 0, 0, 0, 0);
    @(negedge CLK) RST_N = 1'b1;
    cycle(1, 2'b01, 0, 4'b0000, 4'b0000, 0);
    chk_all("post_rst_sr", 0, 4'b1111, 1, 1);
    cycle(1, 2'b00, 0, 4'b1111, 4'b1111, 1);
    chk_model("post_rst_clr");

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 9) == 0));
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
Parametrised bank of WIDTH clocked set/reset storage elements with active-low (default) or active-high S/R inputs. A mode register selects SR, JK, D or T next-state behaviour for the whole bank. Invalid SR combinations (both S and R asserted) are detected, reported per channel and sticky. Used as the general-purpose flag/latch bank wherever single SR flip-flops were previously instantiated one by one.

Parameters:
WIDTH, 8, number of flip-flop channels
ACTIVE_LOW, 1, 1: S/R asserted when 0; 0: S/R asserted when 1
CNT_W, 8, width of invalid-event counter

Ports:
CLK  input  1  clock, rising-edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  bank enable; 0 holds all state except error clear
MODE  input  2  00 SR, 01 JK, 10 D, 11 T; loaded on MODE_LD
MODE_LD  input  1  strobe: load MODE into mode register at next edge
S  input  WIDTH  per-channel set / J / D / T input (polarity per ACTIVE_LOW)
R  input  WIDTH  per-channel reset / K input (polarity per ACTIVE_LOW)
CLR_ERR  input  1  clears ERR_VEC, ERR, ERR_CNT
Q  output  WIDTH  registered state
QBAR  output  WIDTH  always ~Q
ERR_VEC  output  WIDTH  sticky per-channel invalid flag
ERR  output  1  OR of ERR_VEC
ERR_CNT  output  CNT_W  saturating count of cycles with any invalid channel

Behaviour:
- Internal asserted levels: s = ACTIVE_LOW ? ~S : S; r likewise.
- Reset (RST_N=0, asynchronous, immediate): Q=0, QBAR=all ones, ERR_VEC=0, ERR=0, ERR_CNT=0, mode_r=00 (SR).
- All outputs registered; 1-cycle latency from inputs to Q; no combinational path S/R to Q.
- mode_r: on edge with MODE_LD=1, mode_r<=MODE (independent of EN). New mode governs the following edge, not the loading edge.
- Per channel, on edge with EN=1, by mode_r:
  - SR: s,r = 0,0 hold; 0,1 Q<=0; 1,0 Q<=1; 1,1 invalid: Q holds, ERR_VEC bit set.
  - JK: 0,0 hold; 0,1 Q<=0; 1,0 Q<=1; 1,1 Q<=~Q (not invalid).
  - D: Q<=s; r ignored.
  - T: s=1 Q<=~Q; s=0 hold; r ignored.
- EN=0: Q holds; no invalid detection; MODE_LD and CLR_ERR still act.
- Invalid detection only in SR mode with EN=1.
- ERR_CNT increments by 1 per edge on which at least one channel is invalid (not per channel); saturates at 2^CNT_W-1, no wrap.
- CLR_ERR=1 at an edge: ERR_VEC, ERR, ERR_CNT cleared; if an invalid event occurs on the same edge, the new event wins: affected ERR_VEC bits=1, ERR=1, ERR_CNT=1.
- ERR is registered alongside ERR_VEC (same edge).
- Reset mid-operation discards mode_r and all error state; operation resumes in SR mode on first edge after RST_N rises.

Optional Feature:
Macro SR_FF_BANK_ERR_CNT_EN. Defined: ERR_CNT counter implemented as above. Not defined: counter logic omitted, ERR_CNT port retained and tied to 0; ERR_VEC and ERR unaffected.

Test Plan:
WIDTH=4, ACTIVE_LOW=1, CNT_W=2, macro defined unless noted.
1. Hold RST_N=0 then release; assert RST_N=0 mid-cycle later with Q=0101 -> Q=0000, QBAR=1111, ERR=0, ERR_CNT=0 immediately, no clock edge needed.
2. SR mode, EN=1: S=1110,R=1111 -> Q=0001 next edge; S=1111,R=1110 -> Q=0000; S=R=1111 -> Q holds 0000, ERR=0.
3. From Q=0001, S=R=0111 -> Q=0001, ERR_VEC=1000, ERR=1, ERR_CNT=1; keep 4 more cycles -> ERR_CNT saturates at 3; then CLR_ERR=1 with S=R=1111 -> ERR_VEC=0, ERR=0, ERR_CNT=0; repeat with CLR_ERR=1 and S=R=0111 simultaneously -> ERR_VEC=1000, ERR_CNT=1.
4. MODE=01, MODE_LD=1 one cycle, then S=R=0000 from Q=0101 -> Q=1010, 0101, 1010 on successive edges; ERR stays 0. MODE=10 loaded -> Q follows ~S one cycle later; MODE=11, S=1100 -> bits 1:0 toggle each edge.
5. EN=0 with SR mode, S=0000,R=1111 -> Q unchanged for 3 edges, ERR unchanged; S=R=0000 with EN=0 -> no ERR_VEC set.
6. Macro undefined: repeat scenario 3 -> ERR_VEC/ERR identical, ERR_CNT constant 0.
